// File: rtl/alarm_ringer_pkg.sv
// Shared types and constants for the alarm ringer: state encodings,
// LED patterns and counter widths used by the RTL and its bench.
package alarm_ringer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int LED_W  = 10;
  localparam int TICK_W = 25;
  localparam int SNZ_W  = 8;

  localparam logic [LED_W-1:0] LED_OFF   = 10'b00_0000_0000;
  localparam logic [LED_W-1:0] LED_FIRST = 10'b00_0000_0001;

  // Rotate left by one, bit 9 wraps into bit 0.
  function automatic logic [LED_W-1:0] led_rotl(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage

// File: rtl/alarm_ringer_key_debounce.sv
// One pushbutton path: 2-flop synchronizer, level debouncer, and a
// single-cycle press pulse on the debounced 1->0 edge.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Counter runs only while the synchronized level disagrees with the accepted one.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_CYC)) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d = deb_q & ~deb_d;
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings an LED pattern while the alarm window is open, with
// debounced snooze/stop keys and tick-timed snooze.
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int TICK_DIV     = 25000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SNOOZE_TICKS = 240
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             sign_alarm,
  input  logic             key_snooze_n,
  input  logic             key_stop_n,
  output logic [LED_W-1:0] led_ring,
  output logic             ringing,
  output logic [1:0]       state_o
);

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SNZ_W-1:0]   snz_q, snz_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               ringing_q, ringing_d;
  logic               tick_s, snooze_p, stop_p;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_snooze (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .key_n_i (key_snooze_n),
    .press_o (snooze_p)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_stop (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .key_n_i (key_stop_n),
    .press_o (stop_p)
  );

  assign tick_s = (tick_q == TICK_W'(TICK_DIV - 1));

  // Next state, counters and LED pattern; stop always outranks snooze.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_s ? '0 : tick_q + TICK_W'(1);
    snz_d   = snz_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (sign_alarm) begin
          state_d = RING;
          led_d   = LED_FIRST;
        end else begin
          led_d   = LED_OFF;
        end
      end
      RING: begin
        if (stop_p) begin
          state_d = DONE;
          led_d   = LED_OFF;
        end else if (snooze_p) begin
          state_d = SNOOZE;
          snz_d   = SNZ_W'(SNOOZE_TICKS);
          led_d   = LED_OFF;
        end else if (!sign_alarm) begin
          state_d = IDLE;
          led_d   = LED_OFF;
        end else if (tick_s) begin
          led_d   = led_rotl(led_q);
        end else begin
          led_d   = led_q;
        end
      end
      SNOOZE: begin
        if (stop_p) begin
          state_d = DONE;
          led_d   = LED_OFF;
        end else if (!sign_alarm) begin
          state_d = IDLE;
          led_d   = LED_OFF;
        end else if (tick_s) begin
          if (snz_q == SNZ_W'(1)) begin
            state_d = RING;
            snz_d   = '0;
            led_d   = LED_FIRST;
          end else begin
            snz_d   = snz_q - SNZ_W'(1);
            led_d   = ~led_q;
          end
        end else begin
          led_d   = led_q;
        end
      end
      DONE: begin
        led_d = LED_OFF;
        if (!sign_alarm) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = LED_OFF;
      end
    endcase
    if (state_d != state_q) begin
      tick_d = '0;
    end else begin
      tick_d = tick_d;
    end
    ringing_d = (state_d == RING);
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      snz_q     <= '0;
      led_q     <= LED_OFF;
      ringing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      snz_q     <= snz_d;
      led_q     <= led_d;
      ringing_q <= ringing_d;
    end
  end

  assign led_ring = led_q;
  assign ringing  = ringing_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with TICK_DIV=5, DEBOUNCE_CYC=4, SNOOZE_TICKS=3.
// A held key is accepted 7 edges after it is driven low (2 sync + 4 debounce + 1 FSM).
module tb_alarm_ringer;
  import alarm_ringer_pkg::*;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       sign_alarm = 1'b0;
  logic       key_snooze_n = 1'b1;
  logic       key_stop_n = 1'b1;
  logic [9:0] led_ring;
  logic       ringing;
  logic [1:0] state_o;

  int vectors = 0;
  int misses  = 0;

  alarm_ringer #(
    .TICK_DIV     (5),
    .DEBOUNCE_CYC (4),
    .SNOOZE_TICKS (3)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .sign_alarm   (sign_alarm),
    .key_snooze_n (key_snooze_n),
    .key_stop_n   (key_stop_n),
    .led_ring     (led_ring),
    .ringing      (ringing),
    .state_o      (state_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st,
                         input logic rg, input logic [9:0] led);
    chk({tag, ".state"}, {8'd0, state_o}, {8'd0, st});
    chk({tag, ".ringing"}, {9'd0, ringing}, {9'd0, rg});
    chk({tag, ".led"}, led_ring, led);
  endtask

  initial begin
    // reset state
    #3;
    chk_all("reset", 2'd0, 1'b0, LED_OFF);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk_all("idle", 2'd0, 1'b0, LED_OFF);

    // ring entry and rotation
    sign_alarm = 1'b1;
    step(1);
    chk_all("ring_entry", 2'd1, 1'b1, 10'h001);
    step(5);
    chk("ring_tick1", led_ring, 10'h002);
    step(40);
    chk("ring_tick9", led_ring, 10'h200);
    step(5);
    chk("ring_tick10", led_ring, 10'h001);

    // snooze: held 10 cycles, toggles per tick, re-rings after 3 ticks
    key_snooze_n = 1'b0;
    step(7);
    chk_all("snooze_entry", 2'd2, 1'b0, 10'h000);
    step(3);
    key_snooze_n = 1'b1;
    step(2);
    chk("snooze_tick1", led_ring, 10'h3FF);
    step(5);
    chk("snooze_tick2", led_ring, 10'h000);
    step(5);
    chk_all("snooze_rering", 2'd1, 1'b1, 10'h001);

    // stop: glitch rejected, real press goes DONE, re-press ignored
    key_stop_n = 1'b0;
    step(2);
    key_stop_n = 1'b1;
    step(10);
    chk("stop_glitch", {8'd0, state_o}, 10'd1);
    key_stop_n = 1'b0;
    step(7);
    chk_all("stop_done", 2'd3, 1'b0, LED_OFF);
    step(3);
    key_stop_n = 1'b1;
    step(10);
    key_stop_n = 1'b0;
    key_snooze_n = 1'b0;
    step(10);
    key_stop_n = 1'b1;
    key_snooze_n = 1'b1;
    step(10);
    chk("done_hold", {8'd0, state_o}, 10'd3);
    sign_alarm = 1'b0;
    step(1);
    chk_all("done_idle", 2'd0, 1'b0, LED_OFF);

    // simultaneous keys resolve to stop
    sign_alarm = 1'b1;
    step(1);
    chk("both_ring", {8'd0, state_o}, 10'd1);
    key_stop_n = 1'b0;
    key_snooze_n = 1'b0;
    step(7);
    chk_all("both_done", 2'd3, 1'b0, LED_OFF);
    key_stop_n = 1'b1;
    key_snooze_n = 1'b1;
    step(10);
    sign_alarm = 1'b0;
    step(1);
    chk("both_idle", {8'd0, state_o}, 10'd0);

    // window closes during snooze
    sign_alarm = 1'b1;
    step(1);
    key_snooze_n = 1'b0;
    step(7);
    chk("win_snooze", {8'd0, state_o}, 10'd2);
    step(3);
    key_snooze_n = 1'b1;
    sign_alarm = 1'b0;
    step(1);
    chk_all("win_idle", 2'd0, 1'b0, LED_OFF);
    sign_alarm = 1'b1;
    step(1);
    chk_all("win_rering", 2'd1, 1'b1, 10'h001);

    // asynchronous reset mid-ring, re-ring on first edge after release
    step(8);
    chk("pre_rst_led", led_ring, 10'h002);
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 2'd0, 1'b0, LED_OFF);
    #2;
    rst_n = 1'b1;
    step(1);
    chk_all("rst_rering", 2'd1, 1'b1, 10'h001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
